page_quad_seq: RTL and testbench
================================

PAGE_QUAD_SEQ -- requirements
Module: page_quad_seq

Interface
REQ-001 Parameter RST_CYCLES, default 16: number of cycles leaf reset is held asserted; legal range 1..65535.
REQ-002 Parameter SETTLE_CYCLES, default 4: idle cycles between reset release and ap_start; legal range 0..65535.
REQ-003 Parameter TIMEOUT, default 1024: maximum cycles spent waiting for leaf_done; 0 disables the timeout; legal range 0..65535.
REQ-004 clk  input  1  the single clock; all logic on rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_op  input  2  00 RESET, 01 START, 10 RESEND, 11 FULL (reset, settle, start).
REQ-008 cmd_mask  input  4  selects leaves 0..3 targeted by the command.
REQ-009 cmd_ready  output  1  command accept; a transfer occurs when cmd_valid and cmd_ready are both high.
REQ-010 leaf_done  input  4  per-leaf completion level from leaf pages.
REQ-011 reset_leaf  output  4  per-leaf active-high reset, driven to page reset_0..reset_3.
REQ-012 ap_start_leaf  output  4  per-leaf start pulse, driven to page ap_start_0..ap_start_3.
REQ-013 resend_leaf  output  4  per-leaf resend pulse, driven to page resend_0..resend_3.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 cmd_done  output  1  one-cycle pulse on command completion.
REQ-016 cmd_err  output  1  valid with cmd_done; 1 = timeout.
REQ-017 done_seen  output  4  sticky per-leaf record of leaf_done observed during the last START/FULL.

Function
REQ-018 FSM states: IDLE, RST, SETTLE, START, WAIT, RESEND, DONE.
REQ-019 cmd_ready SHALL equal 1 only in IDLE; commands presented in any other state are held off, never dropped.
REQ-020 On accept, cmd_op and cmd_mask SHALL be latched into op_q and mask_q; later changes of cmd_* inputs are ignored.
REQ-021 Accept with cmd_mask = 0 SHALL go directly to DONE: no leaf output toggles; cmd_done pulses on the next cycle with cmd_err = 0.
REQ-022 RESET or FULL accept SHALL enter RST; reset_leaf = mask_q for exactly RST_CYCLES cycles, starting the cycle after accept.
REQ-023 After RST, RESET SHALL go to DONE; FULL SHALL go to SETTLE for SETTLE_CYCLES cycles with all outputs low; SETTLE_CYCLES = 0 skips SETTLE.
REQ-024 START accept, or FULL leaving SETTLE, SHALL enter START: ap_start_leaf = mask_q for exactly one cycle; done_seen SHALL clear in that cycle.
REQ-025 WAIT: done_seen[i] sets when leaf_done[i] and mask_q[i]; exit to DONE with cmd_err = 0 in the cycle after (done_seen | leaf_done) & mask_q equals mask_q.
REQ-026 WAIT timeout: a 16-bit counter clears on entry and increments each WAIT cycle; when TIMEOUT != 0 and the counter reaches TIMEOUT - 1 without completion, the FSM SHALL go to DONE with cmd_err = 1.
REQ-027 If completion and timeout occur in the same cycle, completion SHALL win (cmd_err = 0).
REQ-028 RESEND accept SHALL enter RESEND: resend_leaf = mask_q for exactly one cycle, then DONE.
REQ-029 DONE: cmd_done = 1 for one cycle, cmd_err valid in that cycle, then IDLE; cmd_ready is first high the cycle after DONE.
REQ-030 Unmasked leaves SHALL see no activity on reset_leaf, ap_start_leaf or resend_leaf for any command.
REQ-031 All outputs SHALL be registered; no combinational path from inputs to outputs except through the state register.

Reset
REQ-032 While reset_n = 0 at a clk edge, the block SHALL enter IDLE and clear the counter, op_q, mask_q, done_seen, cmd_done, cmd_err, ap_start_leaf and resend_leaf.
REQ-033 During reset_n = 0, reset_leaf SHALL be 4'b1111, holding all leaves in reset; it SHALL return to 0 the first cycle after reset_n = 1.
REQ-034 cmd_ready and busy SHALL be 0 during reset; cmd_ready SHALL be 1 from the first cycle after release.
REQ-035 Reset asserted mid-command SHALL abort it: no cmd_done is issued, and REQ-032/033 apply.

Verification
REQ-036 FULL, mask 4'b0101, RST_CYCLES = 16, SETTLE_CYCLES = 4 -> reset_leaf = 0101 for 16 cycles, 4 quiet cycles, ap_start_leaf = 0101 for 1 cycle; leaf_done[0] and leaf_done[2] pulsed at different times -> cmd_done with cmd_err = 0, done_seen = 0101.
REQ-037 START, mask 4'b1111, TIMEOUT = 8, leaf_done[3] never set -> cmd_done exactly 8 WAIT cycles after entry, cmd_err = 1, done_seen = 0111.
REQ-038 RESEND, mask 4'b1000 -> resend_leaf = 1000 for one cycle, cmd_done 2 cycles after accept; cmd_valid held high throughout -> the next command is accepted only after DONE.
REQ-039 cmd_mask = 0 with any op -> no leaf output toggles; cmd_done one cycle after accept.
REQ-040 reset_n = 0 in WAIT for 3 cycles -> reset_leaf = 1111 during reset, no cmd_done, IDLE with cmd_ready = 1 after release.
REQ-041 Completion and timeout in the same cycle (TIMEOUT = 4, leaf_done arriving in the 4th WAIT cycle) -> cmd_err = 0.

Source files
------------

// File: rtl/page_quad_seq.sv
// Sequencer for up to four leaf pages: drives per-leaf reset, start and resend
// strobes from a single command port and tracks per-leaf completion.
module page_quad_seq #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_mask,
    output logic       cmd_ready,
    input  logic [3:0] leaf_done,
    output logic [3:0] reset_leaf,
    output logic [3:0] ap_start_leaf,
    output logic [3:0] resend_leaf,
    output logic       busy,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic [3:0] done_seen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_RESEND,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_RESET  = 2'b00;
    localparam logic [1:0] OP_START  = 2'b01;
    localparam logic [1:0] OP_RESEND = 2'b10;
    localparam logic [1:0] OP_FULL   = 2'b11;

    // Terminal counts; the "- 1" values are only consulted when the count is non-zero.
    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);
    localparam bit          HAS_SETTLE  = (SETTLE_CYCLES != 0);
    localparam bit          HAS_TIMEOUT = (TIMEOUT != 0);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  seen_d;
    logic        err_d;
    logic        accept;

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        mask_d  = mask_q;
        seen_d  = done_seen;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = cmd_op;
                    mask_d = cmd_mask;
                    cnt_d  = '0;
                    if (cmd_mask == 4'b0000) begin
                        state_d = S_DONE;
                    end else begin
                        case (cmd_op)
                            OP_RESET:  state_d = S_RST;
                            OP_START:  state_d = S_START;
                            OP_RESEND: state_d = S_RESEND;
                            OP_FULL:   state_d = S_RST;
                            default:   state_d = S_IDLE;
                        endcase
                    end
                end
            end

            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d = '0;
                    if (op_q == OP_FULL) begin
                        state_d = HAS_SETTLE ? S_SETTLE : S_START;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // Completion is tested before timeout so a simultaneous finish reports success.
                seen_d = done_seen | (leaf_done & mask_q);
                if ((seen_d & mask_q) == mask_q) begin
                    state_d = S_DONE;
                end else if (HAS_TIMEOUT && (cnt_q == TO_LAST)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_RESEND: state_d = S_DONE;

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase

        if (state_d == S_START) begin
            seen_d = 4'b0000;
        end
    end

    // State register and registered outputs, all decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_q          <= OP_RESET;
            mask_q        <= 4'b0000;
            done_seen     <= 4'b0000;
            cmd_done      <= 1'b0;
            cmd_err       <= 1'b0;
            ap_start_leaf <= 4'b0000;
            resend_leaf   <= 4'b0000;
            reset_leaf    <= 4'b1111;
            cmd_ready     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            mask_q        <= mask_d;
            done_seen     <= seen_d;
            cmd_done      <= (state_d == S_DONE);
            cmd_err       <= err_d;
            reset_leaf    <= (state_d == S_RST)    ? mask_d : 4'b0000;
            ap_start_leaf <= (state_d == S_START)  ? mask_d : 4'b0000;
            resend_leaf   <= (state_d == S_RESEND) ? mask_d : 4'b0000;
            cmd_ready     <= (state_d == S_IDLE);
            busy          <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_page_quad_seq.sv
// Directed bench for page_quad_seq: two instances, one with the default reset/settle
// timing and TIMEOUT = 8, one with RST_CYCLES = 2, no settle and TIMEOUT = 4.
module tb_page_quad_seq;

    logic       clk = 1'b0;
    logic       reset_n;

    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [3:0] cmd_mask;
    logic [3:0] leaf_done;
    logic       cmd_ready, busy, cmd_done, cmd_err;
    logic [3:0] reset_leaf, ap_start_leaf, resend_leaf, done_seen;

    logic       cmd_valid_b;
    logic [1:0] cmd_op_b;
    logic [3:0] cmd_mask_b;
    logic [3:0] leaf_done_b;
    logic       cmd_ready_b, busy_b, cmd_done_b, cmd_err_b;
    logic [3:0] reset_leaf_b, ap_start_leaf_b, resend_leaf_b, done_seen_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    page_quad_seq #(.RST_CYCLES(16), .SETTLE_CYCLES(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_ready(cmd_ready),
        .leaf_done(leaf_done), .reset_leaf(reset_leaf), .ap_start_leaf(ap_start_leaf),
        .resend_leaf(resend_leaf), .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .done_seen(done_seen)
    );

    page_quad_seq #(.RST_CYCLES(2), .SETTLE_CYCLES(0), .TIMEOUT(4)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid_b), .cmd_op(cmd_op_b), .cmd_mask(cmd_mask_b), .cmd_ready(cmd_ready_b),
        .leaf_done(leaf_done_b), .reset_leaf(reset_leaf_b), .ap_start_leaf(ap_start_leaf_b),
        .resend_leaf(resend_leaf_b), .busy(busy_b), .cmd_done(cmd_done_b), .cmd_err(cmd_err_b),
        .done_seen(done_seen_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_mask    = 4'b0000;
        leaf_done   = 4'b0000;
        cmd_valid_b = 1'b0;
        cmd_op_b    = 2'b00;
        cmd_mask_b  = 4'b0000;
        leaf_done_b = 4'b0000;

        // Reset state
        tick();
        tick();
        chk("rst_reset_leaf", 16'(reset_leaf), 16'hF);
        chk("rst_cmd_ready", 16'(cmd_ready), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_cmd_done", 16'(cmd_done), 16'h0);
        chk("rst_done_seen", 16'(done_seen), 16'h0);
        chk("rst_ap_start", 16'(ap_start_leaf), 16'h0);
        chk("rst_b_reset_leaf", 16'(reset_leaf_b), 16'hF);
        reset_n = 1'b1;
        tick();
        chk("rel_reset_leaf", 16'(reset_leaf), 16'h0);
        chk("rel_cmd_ready", 16'(cmd_ready), 16'h1);
        chk("rel_busy", 16'(busy), 16'h0);

        // FULL, mask 0101
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_mask  = 4'b0101;
        tick();
        chk("full_rst1_reset_leaf", 16'(reset_leaf), 16'h5);
        chk("full_rst1_cmd_ready", 16'(cmd_ready), 16'h0);
        chk("full_rst1_busy", 16'(busy), 16'h1);
        cmd_valid = 1'b0;
        cmd_mask  = 4'b1111;
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk("full_rst_reset_leaf", 16'(reset_leaf), 16'h5);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("full_settle_reset_leaf", 16'(reset_leaf), 16'h0);
            chk("full_settle_ap_start", 16'(ap_start_leaf), 16'h0);
            chk("full_settle_busy", 16'(busy), 16'h1);
        end
        tick();
        chk("full_start_ap_start", 16'(ap_start_leaf), 16'h5);
        chk("full_start_done_seen", 16'(done_seen), 16'h0);
        tick();
        chk("full_wait1_ap_start", 16'(ap_start_leaf), 16'h0);
        leaf_done = 4'b0001;
        tick();
        chk("full_wait2_done_seen", 16'(done_seen), 16'h1);
        chk("full_wait2_cmd_done", 16'(cmd_done), 16'h0);
        leaf_done = 4'b0010;
        tick();
        chk("full_wait3_done_seen", 16'(done_seen), 16'h1);
        chk("full_wait3_cmd_done", 16'(cmd_done), 16'h0);
        leaf_done = 4'b0100;
        tick();
        chk("full_done_cmd_done", 16'(cmd_done), 16'h1);
        chk("full_done_cmd_err", 16'(cmd_err), 16'h0);
        chk("full_done_done_seen", 16'(done_seen), 16'h5);
        chk("full_done_cmd_ready", 16'(cmd_ready), 16'h0);
        leaf_done = 4'b0000;
        tick();
        chk("full_idle_cmd_done", 16'(cmd_done), 16'h0);
        chk("full_idle_cmd_ready", 16'(cmd_ready), 16'h1);
        chk("full_idle_busy", 16'(busy), 16'h0);

        // START, mask 1111, leaf 3 never completes -> timeout after 8 WAIT cycles
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_mask  = 4'b1111;
        tick();
        chk("to_start_ap_start", 16'(ap_start_leaf), 16'hF);
        chk("to_start_done_seen", 16'(done_seen), 16'h0);
        cmd_valid = 1'b0;
        tick();
        leaf_done = 4'b0111;
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk("to_wait_cmd_done", 16'(cmd_done), 16'h0);
        end
        tick();
        chk("to_done_cmd_done", 16'(cmd_done), 16'h1);
        chk("to_done_cmd_err", 16'(cmd_err), 16'h1);
        chk("to_done_done_seen", 16'(done_seen), 16'h7);
        leaf_done = 4'b0000;
        tick();
        chk("to_idle_cmd_err", 16'(cmd_err), 16'h0);
        chk("to_idle_cmd_ready", 16'(cmd_ready), 16'h1);

        // RESEND, mask 1000, cmd_valid held high into a second RESEND
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_mask  = 4'b1000;
        tick();
        chk("rs_resend_leaf", 16'(resend_leaf), 16'h8);
        chk("rs_cmd_ready", 16'(cmd_ready), 16'h0);
        cmd_mask = 4'b0001;
        tick();
        chk("rs_done_cmd_done", 16'(cmd_done), 16'h1);
        chk("rs_done_resend_leaf", 16'(resend_leaf), 16'h0);
        chk("rs_done_cmd_err", 16'(cmd_err), 16'h0);
        tick();
        chk("rs_idle_cmd_ready", 16'(cmd_ready), 16'h1);
        chk("rs_idle_resend_leaf", 16'(resend_leaf), 16'h0);
        tick();
        chk("rs2_resend_leaf", 16'(resend_leaf), 16'h1);
        cmd_valid = 1'b0;
        tick();
        chk("rs2_done_cmd_done", 16'(cmd_done), 16'h1);
        tick();
        chk("rs2_idle_done_seen", 16'(done_seen), 16'h7);

        // Zero mask: straight to DONE, no leaf activity, done_seen untouched
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_mask  = 4'b0000;
        tick();
        chk("z_cmd_done", 16'(cmd_done), 16'h1);
        chk("z_cmd_err", 16'(cmd_err), 16'h0);
        chk("z_reset_leaf", 16'(reset_leaf), 16'h0);
        chk("z_ap_start", 16'(ap_start_leaf), 16'h0);
        cmd_op = 2'b01;
        tick();
        chk("z_idle_cmd_ready", 16'(cmd_ready), 16'h1);
        tick();
        chk("z2_cmd_done", 16'(cmd_done), 16'h1);
        chk("z2_ap_start", 16'(ap_start_leaf), 16'h0);
        chk("z2_done_seen", 16'(done_seen), 16'h7);
        cmd_valid = 1'b0;
        tick();

        // Reset during WAIT aborts the command
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_mask  = 4'b0011;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("ab_wait_busy", 16'(busy), 16'h1);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ab_rst_reset_leaf", 16'(reset_leaf), 16'hF);
            chk("ab_rst_cmd_done", 16'(cmd_done), 16'h0);
            chk("ab_rst_cmd_ready", 16'(cmd_ready), 16'h0);
            chk("ab_rst_busy", 16'(busy), 16'h0);
        end
        reset_n = 1'b1;
        tick();
        chk("ab_rel_cmd_ready", 16'(cmd_ready), 16'h1);
        chk("ab_rel_reset_leaf", 16'(reset_leaf), 16'h0);
        chk("ab_rel_done_seen", 16'(done_seen), 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ab_idle_cmd_done", 16'(cmd_done), 16'h0);
        end

        // Second instance: FULL without settle, completion on the last timeout cycle
        cmd_valid_b = 1'b1;
        cmd_op_b    = 2'b11;
        cmd_mask_b  = 4'b0001;
        tick();
        chk("b_rst1_reset_leaf", 16'(reset_leaf_b), 16'h1);
        cmd_valid_b = 1'b0;
        tick();
        chk("b_rst2_reset_leaf", 16'(reset_leaf_b), 16'h1);
        tick();
        chk("b_start_ap_start", 16'(ap_start_leaf_b), 16'h1);
        chk("b_start_reset_leaf", 16'(reset_leaf_b), 16'h0);
        tick();
        tick();
        tick();
        tick();
        leaf_done_b = 4'b0001;
        chk("b_wait4_cmd_done", 16'(cmd_done_b), 16'h0);
        tick();
        chk("b_tie_cmd_done", 16'(cmd_done_b), 16'h1);
        chk("b_tie_cmd_err", 16'(cmd_err_b), 16'h0);
        chk("b_tie_done_seen", 16'(done_seen_b), 16'h1);
        leaf_done_b = 4'b0000;
        tick();

        // Second instance: START with no completion -> timeout after 4 WAIT cycles
        cmd_valid_b = 1'b1;
        cmd_op_b    = 2'b01;
        tick();
        chk("b2_start_done_seen", 16'(done_seen_b), 16'h0);
        cmd_valid_b = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("b2_wait4_cmd_done", 16'(cmd_done_b), 16'h0);
        tick();
        chk("b2_to_cmd_done", 16'(cmd_done_b), 16'h1);
        chk("b2_to_cmd_err", 16'(cmd_err_b), 16'h1);
        tick();
        chk("b2_idle_cmd_ready", 16'(cmd_ready_b), 16'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
